// File: rtl/final_bits_pkg.sv
// rtl/final_bits_pkg.sv - shared types and constants for the final-bits flusher
package final_bits_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } flush_state_t;

    localparam int FLUSH_M  = 'h3FFF;
    localparam int CNT_BIAS = 10;

    // Worst case chunk count: largest positive counter plus bias, rounded up to whole chunks.
    function automatic int MAX_CHUNKS(input int d_size, input int out_w);
        return ((1 << (d_size - 1)) - 1 + CNT_BIAS + out_w - 1) / out_w;
    endfunction

endpackage

// File: rtl/final_chunk_extract.sv
// rtl/final_chunk_extract.sv - signed-shift chunk extraction and tail mask for the flush loop
module final_chunk_extract #(
    parameter int OUT_W = 8,
    parameter int E_W   = 25,
    parameter int SH_W  = 6
) (
    input  logic [E_W-1:0]   e,
    input  logic [SH_W-1:0]  sh,
    output logic [OUT_W-1:0] data,
    output logic             carry,
    output logic [E_W-1:0]   e_masked
);

    localparam int P = 1 << (SH_W - 1);

    logic [E_W+P-1:0]  ext;
    logic [SH_W-1:0]   shamt;
    logic [OUT_W:0]    win;
    int                top;

    // Pre-padding by P zeros turns every signed shift into a plain right shift.
    always_comb begin
        ext   = {e, {P{1'b0}}};
        shamt = {~sh[SH_W-1], sh[SH_W-2:0]};
        win   = (OUT_W + 1)'(ext >> shamt);
        data  = win[OUT_W-1:0];
        carry = win[OUT_W];
        top   = int'($signed(sh)) + OUT_W;
        if (top >= E_W) begin
            e_masked = e;
        end else if (top <= 0) begin
            e_masked = '0;
        end else begin
            e_masked = e & ~({E_W{1'b1}} << top);
        end
    end

endmodule

// File: rtl/final_bits_flusher.sv
// rtl/final_bits_flusher.sv - sequential flush of the terminal (cnt, low) pair into output chunks
module final_bits_flusher
    import final_bits_pkg::*;
#(
    parameter int OUT_W     = 8,
    parameter int LOW_WIDTH = 24,
    parameter int D_SIZE    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_SIZE-1:0]    in_cnt,
    input  logic [LOW_WIDTH-1:0] in_low,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_carry,
    output logic                 out_last,
    output logic                 done,
    output logic [2:0]           done_count
);

    localparam int E_W     = LOW_WIDTH + 1;
    localparam int SH_W    = D_SIZE + 1;
    localparam int CNT_W   = $clog2(MAX_CHUNKS(D_SIZE, OUT_W) + 1);
    localparam int SH_BIAS = 24;

    flush_state_t     state, state_next;
    logic [E_W-1:0]   e_q, e_init, e_masked, m_vec;
    logic [SH_W-1:0]  sh_q, sh_init;
    logic [CNT_W-1:0] remaining, k_q, k_init;
    logic             first_q, done_q;
    logic [2:0]       done_count_q;
    logic [OUT_W-1:0] chunk_data;
    logic             chunk_carry;
    logic             accept, take, last_take;
    int               c_i, s_i;

    always_comb begin
        m_vec   = E_W'(FLUSH_M);
        e_init  = ((E_W'(in_low) + m_vec) & ~m_vec) | (m_vec + E_W'(1));
        c_i     = int'($signed(in_cnt));
        s_i     = c_i + CNT_BIAS;
        sh_init = SH_W'(c_i + SH_BIAS - OUT_W);
        k_init  = (s_i <= 0) ? '0 : CNT_W'((s_i + OUT_W - 1) / OUT_W);
    end

    final_chunk_extract #(
        .OUT_W (OUT_W),
        .E_W   (E_W),
        .SH_W  (SH_W)
    ) u_extract (
        .e        (e_q),
        .sh       (sh_q),
        .data     (chunk_data),
        .carry    (chunk_carry),
        .e_masked (e_masked)
    );

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == EMIT);
    assign out_data   = out_valid ? chunk_data : '0;
    assign out_carry  = out_valid & first_q & chunk_carry;
    assign out_last   = out_valid & (remaining == CNT_W'(1));
    assign done       = done_q;
    assign done_count = done_count_q;

    assign accept    = in_ready & in_valid;
    assign take      = out_valid & out_ready;
    assign last_take = take & (remaining == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && k_init != '0) state_next = EMIT;
            EMIT: if (last_take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q          <= '0;
            sh_q         <= '0;
            remaining    <= '0;
            k_q          <= '0;
            first_q      <= 1'b0;
            done_q       <= 1'b0;
            done_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                e_q       <= e_init;
                sh_q      <= sh_init;
                remaining <= k_init;
                k_q       <= k_init;
                first_q   <= 1'b1;
                // Nothing to emit: report completion straight away.
                if (k_init == '0) begin
                    done_q       <= 1'b1;
                    done_count_q <= '0;
                end
            end else if (take) begin
                e_q       <= e_masked;
                sh_q      <= sh_q - SH_W'(OUT_W);
                remaining <= remaining - CNT_W'(1);
                first_q   <= 1'b0;
                if (last_take) begin
                    done_q       <= 1'b1;
                    done_count_q <= 3'(k_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_final_bits_flusher.sv
// tb/tb_final_bits_flusher.sv - scoreboard bench for final_bits_flusher at OUT_W 8 and 16
module tb_final_bits_flusher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  in_cnt = '0;
    logic [23:0] in_low = '0;
    logic        out_ready = 1'b1;
    logic        sel = 1'b0;
    int          rdy_mode = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    logic        a_in_ready, a_out_valid, a_out_carry, a_out_last, a_done;
    logic [7:0]  a_out_data;
    logic [2:0]  a_done_count;
    logic        b_in_ready, b_out_valid, b_out_carry, b_out_last, b_done;
    logic [15:0] b_out_data;
    logic [2:0]  b_done_count;

    final_bits_flusher #(.OUT_W(8), .LOW_WIDTH(24), .D_SIZE(5)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
        .in_cnt(in_cnt), .in_low(in_low), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_carry(a_out_carry), .out_last(a_out_last),
        .done(a_done), .done_count(a_done_count));

    final_bits_flusher #(.OUT_W(16), .LOW_WIDTH(24), .D_SIZE(5)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel), .in_ready(b_in_ready),
        .in_cnt(in_cnt), .in_low(in_low), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_carry(b_out_carry), .out_last(b_out_last),
        .done(b_done), .done_count(b_done_count));

    logic        m_ready, m_valid, m_carry, m_last, m_done;
    logic [15:0] m_data;
    logic [2:0]  m_cnt;

    always_comb begin
        m_ready = sel ? b_in_ready  : a_in_ready;
        m_valid = sel ? b_out_valid : a_out_valid;
        m_carry = sel ? b_out_carry : a_out_carry;
        m_last  = sel ? b_out_last  : a_out_last;
        m_done  = sel ? b_done      : a_done;
        m_data  = sel ? b_out_data  : {8'h00, a_out_data};
        m_cnt   = sel ? b_done_count : a_done_count;
    end

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        last;
    } chunk_t;

    chunk_t exp_q[$];
    int     exp_done_q[$];
    chunk_t cur;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: e viewed as a plain integer scaled by 2^8 so every window is a
    // non-negative power-of-two slice; chunk i covers bits [top-1 : top-w] of what remains.
    task automatic model_push(input int c, input logic [23:0] low, input int w, output int k);
        longint m, e, big, top, lo;
        chunk_t x;
        int s;
        m   = 64'h3FFF;
        e   = ((longint'(low) + m) & ~m) | (m + 1);
        big = e << 8;
        s   = c + 10;
        k   = (s <= 0) ? 0 : (s + w - 1) / w;
        for (int i = 0; i < k; i++) begin
            top     = longint'(c + 24 - w * i + 8);
            lo      = top - w;
            x.data  = 16'((big % (longint'(1) << top)) >> lo);
            x.carry = (i == 0) ? 1'((big >> top) & 1) : 1'b0;
            x.last  = (i == k - 1);
            exp_q.push_back(x);
        end
        exp_done_q.push_back(k);
    endtask

    logic        held = 1'b0;
    logic [15:0] h_data;
    logic        h_carry, h_last;

    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (m_valid) begin
                if (held) begin
                    check("hold_data", m_data, h_data);
                    check("hold_carry", m_carry, h_carry);
                    check("hold_last", m_last, h_last);
                end
                if (out_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_chunk: got %0h expected none", m_data);
                    end else begin
                        cur = exp_q.pop_front();
                        check("chunk_data", m_data, cur.data);
                        check("chunk_carry", m_carry, cur.carry);
                        check("chunk_last", m_last, cur.last);
                    end
                end else begin
                    held = 1'b1; h_data = m_data; h_carry = m_carry; h_last = m_last;
                end
            end
            if (m_done) begin
                if (exp_done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got count %0d expected no done", m_cnt);
                end else begin
                    check("done_count", m_cnt, exp_done_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(1, 0));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic send(input int c, input logic [23:0] low);
        int k, guard;
        guard = 0;
        while (!m_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        if (!m_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
            return;
        end
        in_cnt = 5'(c); in_low = low; in_valid = 1'b1;
        model_push(c, low, sel ? 16 : 8, k);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (k == 0) check("done_latency", m_done, 1);
        else        check("valid_latency", m_valid, 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || exp_done_q.size() != 0) && g < 500) begin
            @(posedge clk); #1; g++;
        end
        if (exp_q.size() != 0 || exp_done_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d chunks pending expected 0", exp_q.size());
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", m_ready, 1);
        check("rst_out_valid", m_valid, 0);
        check("rst_out_data", m_data, 0);
        check("rst_out_carry", m_carry, 0);
        check("rst_out_last", m_last, 0);
        check("rst_done", m_done, 0);
        check("rst_done_count", m_cnt, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        send(0, 24'h001234);   drain();
        send(0, 24'hFFFFFF);   drain();
        send(7, 24'hFFFFFF);   drain();
        send(-10, 24'hABCDEF); drain();
        send(-16, 24'h000000); drain();
        send(15, 24'h7FC000);  drain();

        rdy_mode = 1;
        repeat (40) send(int'($urandom_range(31, 0)) - 16, 24'($urandom));
        drain();

        rdy_mode = 0;
        sel = 1'b1;
        send(-9, 24'h000000); drain();
        send(15, 24'hFFFFFF); drain();
        rdy_mode = 1;
        repeat (20) send(int'($urandom_range(31, 0)) - 16, 24'($urandom));
        drain();
        rdy_mode = 0;
        sel = 1'b0;

        send(7, 24'hFFFFFF);
        @(posedge clk); #2;
        rdy_mode = 2; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rdy_mode = 0; out_ready = 1'b1;
        drain();

        rdy_mode = 2; out_ready = 1'b0;
        send(7, 24'hFFFFFF);
        @(posedge clk); #2;
        reset = 1'b1;
        exp_q.delete();
        exp_done_q.delete();
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        rdy_mode = 0; out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("no_done_after_reset", m_done, 0);
        end
        send(0, 24'h001234);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
